// File: rtl/instruction_sequencer_if.sv
// Bundle of the debug-controller / datapath signals around the instruction
// sequencer. The master side drives the stall, halt and debug requests; the
// slave side (the sequencer) drives the phase vector and status.
interface instruction_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int STEP_W     = 8
);
  logic                  wait_req;
  logic                  haltx;
  logic                  debug_stop;
  logic                  debug_mode;
  logic                  debug_step_req;
  logic [STEP_W-1:0]     debug_step_count;
  logic [NUM_PHASES-1:0] phase;
  logic                  stopped;
  logic                  halted;
  logic                  pc_enx;
  logic                  retire;
  logic                  debug_step_ack;
  logic                  debug_active;

  modport master (
    output wait_req, haltx, debug_stop, debug_mode, debug_step_req, debug_step_count,
    input  phase, stopped, halted, pc_enx, retire, debug_step_ack, debug_active
  );

  modport slave (
    input  wait_req, haltx, debug_stop, debug_mode, debug_step_req, debug_step_count,
    output phase, stopped, halted, pc_enx, retire, debug_step_ack, debug_active
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Instruction phase sequencer: walks a one-hot phase vector of NUM_PHASES
// entries (phase 0 = FETCH, last = COMMIT), stretches phases on wait, stops at
// instruction boundaries for debug, runs multi-instruction debug steps and
// parks in a halt state on request from the executing instruction.
module instruction_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int STEP_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  instruction_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPED, S_HALTED} state_t;

  localparam logic [NUM_PHASES-1:0] FETCH_OH  = NUM_PHASES'(1);
  localparam logic [NUM_PHASES-1:0] PHASE1_OH = NUM_PHASES'(2);
  localparam logic [STEP_W-1:0]     ONE       = STEP_W'(1);

  state_t                state, state_nx;
  // Phase register is all zero outside RUN, so it doubles as the output.
  logic [NUM_PHASES-1:0] phase_q, phase_nx;
  logic [STEP_W-1:0]     count_q, count_nx;
  logic                  active_q, active_nx;
  logic                  mode_q, mode_nx;
  logic                  ack_q, ack_nx;

  logic fetch, commit, step_done, stop_cond, retire;

  assign fetch     = phase_q[0];
  assign commit    = phase_q[NUM_PHASES-1];
  assign step_done = active_q & (count_q == '0);
  // A step in progress overrides a plain debug stop request at the boundary.
  assign stop_cond = (bus.debug_stop & ~active_q) | step_done;
  assign retire    = commit & ~bus.wait_req;

  assign bus.phase          = phase_q;
  assign bus.stopped        = (state == S_STOPPED);
  assign bus.halted         = (state == S_HALTED);
  assign bus.pc_enx         = fetch & ~bus.wait_req & ~stop_cond;
  assign bus.retire         = retire;
  assign bus.debug_step_ack = ack_q;
  assign bus.debug_active   = (state == S_STOPPED) | (active_q & mode_q);

  // State, phase and step bookkeeping registers; reset returns to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      phase_q  <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
      mode_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      phase_q  <= phase_nx;
      count_q  <= count_nx;
      active_q <= active_nx;
      mode_q   <= mode_nx;
      ack_q    <= ack_nx;
    end
  end

  // Next-state logic: phase advance, boundary stop, step load/finish, halt.
  always_comb begin
    logic set_ack;
    state_nx  = state;
    phase_nx  = phase_q;
    count_nx  = count_q;
    active_nx = active_q;
    mode_nx   = mode_q;
    set_ack   = 1'b0;

    if (retire && active_q && (count_q != '0)) begin
      count_nx = count_q - ONE;
    end

    case (state)
      S_IDLE: begin
        state_nx = S_RUN;
        phase_nx = FETCH_OH;
      end
      S_RUN: begin
        if (!bus.wait_req) begin
          if (commit) begin
            if (bus.haltx) begin
              state_nx = S_HALTED;
              phase_nx = '0;
              // Halting abandons any step; the debugger still gets its ack.
              if (active_q) begin
                active_nx = 1'b0;
                set_ack   = 1'b1;
              end
            end else begin
              phase_nx = FETCH_OH;
            end
          end else if (fetch && stop_cond) begin
            // The fetched instruction is held and resumes from phase 1.
            state_nx = S_STOPPED;
            phase_nx = '0;
            if (step_done) begin
              active_nx = 1'b0;
              set_ack   = 1'b1;
            end
          end else begin
            phase_nx = phase_q << 1;
          end
        end
      end
      S_STOPPED: begin
        if (bus.debug_step_req && !ack_q) begin
          count_nx  = (bus.debug_step_count == '0) ? ONE : bus.debug_step_count;
          mode_nx   = bus.debug_mode;
          active_nx = 1'b1;
          state_nx  = S_RUN;
          phase_nx  = PHASE1_OH;
        end else if (!bus.debug_stop) begin
          state_nx = S_RUN;
          phase_nx = PHASE1_OH;
        end
      end
      S_HALTED: begin
        if (!bus.haltx) begin
          state_nx = S_RUN;
          phase_nx = FETCH_OH;
        end
      end
      default: begin
        state_nx = S_IDLE;
        phase_nx = '0;
      end
    endcase

    // Ack is held until the requester drops its level, then clears.
    if (set_ack) begin
      ack_nx = 1'b1;
    end else if (!bus.debug_step_req) begin
      ack_nx = 1'b0;
    end else begin
      ack_nx = ack_q;
    end
  end
endmodule
